// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end of a 5-stage RISC-V pipeline.
// Owns the PC register and the IF/ID pipeline register, applies load-use
// stalls and branch-taken flushes, and keeps saturating stall/flush counters.
// A two-state run FSM (IDLE/RUN) gates every update on start_i.
//
// Pipeline-register semantics: if_id_valid_o=1 means IF/ID holds a real
// instruction fetched from imem_addr_o on the previous advancing edge.
// A flush injects NOP_INSTR with valid=0. A stall freezes IF/ID and the PC.
// There is no ready/back-pressure path out of this stage other than stall_i.
`timescale 1ns/1ps

module fetch_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic [XLEN-1:0]  imem_instr_i,
  output logic [XLEN-1:0]  imem_addr_o,
  output logic [XLEN-1:0]  if_id_pc_o,
  output logic [XLEN-1:0]  if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             running_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0]   if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // Per-edge qualifiers; only meaningful while already in RUN with start held.
  logic              active;
  logic              do_stall;
  logic              do_flush;
  logic              do_fetch;
  logic [XLEN-1:0]   target_aligned;
  logic [XLEN-1:0]   pc_plus4;

  // Targets are forced word-aligned; PC+4 wraps modulo 2^XLEN silently.
  assign target_aligned = branch_target_i & ~(XLEN'(3));
  assign pc_plus4       = pc_q + XLEN'(4);

  // Priority decode: stop > stall > flush > normal fetch.
  assign active   = (state_q == ST_RUN) && start_i;
  assign do_stall = active && stall_i;
  assign do_flush = active && !stall_i && flush_i;
  assign do_fetch = active && !stall_i && !flush_i;

  // Run FSM next state: follows the level of start_i on every edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i)  state_d = ST_RUN;
      ST_RUN:  if (!start_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // PC and IF/ID next values; everything holds unless fetching or flushing.
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (do_flush) begin
      pc_d          = target_aligned;
      if_id_pc_d    = pc_q;
      if_id_instr_d = NOP_INSTR[XLEN-1:0];
      if_id_valid_d = 1'b0;
    end else if (do_fetch) begin
      pc_d          = pc_plus4;
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_instr_i;
      if_id_valid_d = 1'b1;
    end
  end

  // Performance counters, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (do_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State register bank with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC[XLEN-1:0];
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR[XLEN-1:0];
      if_id_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Outputs come straight from registers; running_o is the FSM state bit.
  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign running_o     = (state_q == ST_RUN);
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A second instance with 2-bit counters
// shares all inputs so counter saturation is reached in a few cycles.
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IOFS = 32'h1000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] target;

  logic [XLEN-1:0] addr, ifpc, ifinstr, instr;
  logic            ifvalid, running;
  logic [31:0]     scnt, fcnt;

  logic [XLEN-1:0] addr2, ifpc2, ifinstr2, instr2;
  logic            ifvalid2, running2;
  logic [1:0]      scnt2, fcnt2;

  // Instruction memory model: data = address + IOFS.
  assign instr  = addr + IOFS;
  assign instr2 = addr2 + IOFS;

  fetch_stage #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .flush_i(flush), .branch_target_i(target), .imem_instr_i(instr),
    .imem_addr_o(addr), .if_id_pc_o(ifpc), .if_id_instr_o(ifinstr),
    .if_id_valid_o(ifvalid), .running_o(running),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  fetch_stage #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .flush_i(flush), .branch_target_i(target), .imem_instr_i(instr2),
    .imem_addr_o(addr2), .if_id_pc_o(ifpc2), .if_id_instr_o(ifinstr2),
    .if_id_valid_o(ifvalid2), .running_o(running2),
    .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full snapshot of the main instance.
  task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                         input logic [31:0] e_instr, input logic e_valid, input logic e_run,
                         input logic [31:0] e_scnt, input logic [31:0] e_fcnt);
    chk({tag, ".addr"},    addr,             e_addr);
    chk({tag, ".if_pc"},   ifpc,             e_pc);
    chk({tag, ".if_inst"}, ifinstr,          e_instr);
    chk({tag, ".valid"},   {31'd0, ifvalid}, {31'd0, e_valid});
    chk({tag, ".run"},     {31'd0, running}, {31'd0, e_run});
    chk({tag, ".scnt"},    scnt,             e_scnt);
    chk({tag, ".fcnt"},    fcnt,             e_fcnt);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; target = '0;
    #2;
    chk_all("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 0, 0);
    chk("reset.sat_scnt", {30'd0, scnt2}, 32'd0);
    rst = 1'b0;
    start = 1'b1;

    // Transition edge: RUN entered, nothing fetched yet.
    step(); chk_all("enter", 32'h0, 32'h0, NOP, 1'b0, 1'b1, 0, 0);
    step(); chk_all("f0", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 1'b1, 0, 0);
    step(); chk_all("f4", 32'h8, 32'h4, 32'h1000_0004, 1'b1, 1'b1, 0, 0);
    step(); chk_all("f8", 32'hC, 32'h8, 32'h1000_0008, 1'b1, 1'b1, 0, 0);
    step(); chk_all("fC", 32'h10, 32'hC, 32'h1000_000C, 1'b1, 1'b1, 0, 0);

    // Three-cycle stall at PC=0x10.
    stall = 1'b1;
    step(); chk_all("stall1", 32'h10, 32'hC, 32'h1000_000C, 1'b1, 1'b1, 1, 0);
    step(); chk_all("stall2", 32'h10, 32'hC, 32'h1000_000C, 1'b1, 1'b1, 2, 0);
    step(); chk_all("stall3", 32'h10, 32'hC, 32'h1000_000C, 1'b1, 1'b1, 3, 0);
    chk("sat.scnt3", {30'd0, scnt2}, 32'd3);
    stall = 1'b0;
    step(); chk_all("resume10", 32'h14, 32'h10, 32'h1000_0010, 1'b1, 1'b1, 3, 0);
    step(); chk_all("resume14", 32'h18, 32'h14, 32'h1000_0014, 1'b1, 1'b1, 3, 0);
    step(); chk_all("f18", 32'h1C, 32'h18, 32'h1000_0018, 1'b1, 1'b1, 3, 0);
    step(); chk_all("f1C", 32'h20, 32'h1C, 32'h1000_001C, 1'b1, 1'b1, 3, 0);

    // Flush at PC=0x20 to unaligned 0x103.
    flush = 1'b1; target = 32'h0000_0103;
    step(); chk_all("flush1", 32'h100, 32'h20, NOP, 1'b0, 1'b1, 3, 1);
    // Back-to-back flush.
    target = 32'h0000_0200;
    step(); chk_all("flush2", 32'h200, 32'h100, NOP, 1'b0, 1'b1, 3, 2);
    // Stall and flush together: stall wins, flush ignored.
    stall = 1'b1; target = 32'h0000_0300;
    step(); chk_all("stallflush", 32'h200, 32'h100, NOP, 1'b0, 1'b1, 4, 2);
    chk("sat.scnt4", {30'd0, scnt2}, 32'd3);
    // Flush to top of address space, then wrap on fetch.
    stall = 1'b0; target = 32'hFFFF_FFFE;
    step(); chk_all("flushtop", 32'hFFFF_FFFC, 32'h200, NOP, 1'b0, 1'b1, 4, 3);
    flush = 1'b0;
    step(); chk_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b1, 1'b1, 4, 3);
    step(); chk_all("after_wrap", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 1'b1, 4, 3);

    // Stop: RUN->IDLE with everything held.
    start = 1'b0;
    step(); chk_all("stop", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 1'b0, 4, 3);
    // IDLE ignores stall and flush.
    stall = 1'b1; flush = 1'b1; target = 32'h0000_0800;
    step(); chk_all("idle_ign", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 1'b0, 4, 3);
    flush = 1'b0;

    // Restart with stall held: transition edge holds, next edge stalls.
    start = 1'b1;
    step(); chk_all("restart", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 1'b1, 4, 3);
    step(); chk_all("stall5", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 1'b1, 5, 3);
    chk("sat.scnt5", {30'd0, scnt2}, 32'd3);
    chk("sat.fcnt", {30'd0, fcnt2}, 32'd3);

    // Asynchronous reset mid-stall, away from any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 0, 0);
    chk("async_rst.sat", {30'd0, scnt2}, 32'd0);
    start = 1'b0; stall = 1'b0;
    #1 rst = 1'b0;
    step(); chk_all("post_rst1", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 0, 0);
    step(); chk_all("post_rst2", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 0, 0);
    start = 1'b1;
    step(); chk_all("rerun", 32'h0, 32'h0, NOP, 1'b0, 1'b1, 0, 0);
    step(); chk_all("refetch", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 1'b1, 0, 0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
